oai22_arc_bist: RTL and testbench
=================================

Name: oai22_arc_bist

Overview:
- Self-test sequencer for one OAI22 cell instance. It drives the cell inputs A1, A2, B1, B2 and reads back its ZN output, so it sits directly upstream and downstream of the cell.
- On START it sweeps all 16 input vectors. For each vector it waits a settle interval, samples ZN and compares it with ~((A1|A2)&(B1|B2)).
- It reports pass/fail, a fail count, a per-vector fail mask and the first failing vector.
- It is used for silicon bring-up and timing-arc sanity checks of the cell library.

Parameters:
- SETTLE_CYCLES, 2, number of cycles between applying a vector and sampling ZN. Legal range 1..15.

Ports:
- CK  input  1  clock, rising edge active
- RN  input  1  asynchronous active-low reset
- START  input  1  sweep request, sampled on CK; one-cycle pulse or level
- ZN  input  1  output of the cell under test
- A1  output  1  cell input, registered
- A2  output  1  cell input, registered
- B1  output  1  cell input, registered
- B2  output  1  cell input, registered
- BUSY  output  1  sweep in progress
- DONE  output  1  sweep complete, results valid, held
- PASS  output  1  DONE and FAIL_CNT==0
- FAIL_CNT  output  5  number of failing vectors, 0..16
- FAIL_MASK  output  16  bit k set means vector k failed
- FIRST_FAIL  output  4  index of the lowest failing vector; 0 if none

Behaviour:
- Clock and reset:
  - One clock, CK. Reset RN is asynchronous and active-low.
  - RN low forces all state and outputs to 0, regardless of state (including mid-sweep). The FSM goes to IDLE.
- Vector encoding: {A1,A2,B1,B2} = vec[3:0]. Vectors are applied in ascending order, 0..15.
- A1..B2 are driven only from flops. They are 0 in IDLE and in DONE.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
  - IDLE, START=1: go to SETTLE with vec=0 and settle counter=0. Clear FAIL_CNT, FAIL_MASK and FIRST_FAIL. Set BUSY=1.
  - SETTLE: counter increments each cycle. When counter==SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE (one cycle):
    - Compare ZN with the expected value. On mismatch: FAIL_MASK[vec]<=1 and FAIL_CNT<=FAIL_CNT+1. If this is the first mismatch, FIRST_FAIL<=vec.
    - If vec==15: go to DONE with BUSY=0 and DONE=1.
    - Otherwise: vec<=vec+1, counter<=0, go to SETTLE.
  - DONE: results are held. START=1 restarts exactly as from IDLE, which clears DONE and the results in the same edge.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - DONE rises 16*(SETTLE_CYCLES+1) edges after the edge that sampled START. This is 48 edges for the default.
- START while BUSY is ignored. No restart and no effect on the results.
- FAIL_CNT is 5 bits with a maximum of 16, so no overflow is possible.
- In simulation, ZN that is X or Z at SAMPLE counts as a mismatch (compare with !==).
- PASS is combinational from DONE and FAIL_CNT, or registered, but it must be 0 whenever DONE=0.

Test Plan:
- Ideal cell model, SETTLE_CYCLES=2, START pulse:
  - DONE=1 exactly 48 edges later.
  - PASS=1, FAIL_CNT=0, FAIL_MASK=16'h0000, FIRST_FAIL=0.
  - A1..B2 step through 0..15, each vector held 3 cycles.
- ZN stuck at 0 -> FAIL_CNT=7, FAIL_MASK=16'h111F, FIRST_FAIL=0, PASS=0.
- ZN stuck at 1 -> FAIL_CNT=9, FAIL_MASK=16'hEEE0, FIRST_FAIL=5, PASS=0.
- RN pulsed low while vec=6 -> all outputs 0 immediately, without waiting for CK. After RN releases, the block stays in IDLE until START. The next sweep on an ideal cell gives PASS=1.
- START re-asserted during a sweep at vec=3 -> ignored; DONE still at edge 48.
- Restart from DONE after a stuck-at-0 run:
  - Results clear on the START edge.
  - The ideal-cell rerun ends with PASS=1.
- Variant with SETTLE_CYCLES=1 -> DONE after 32 edges.

Source files
------------

// File: rtl/oai22_arc_bist_if.sv
// Bundle of every signal exchanged between the OAI22 self-test sequencer
// and its surroundings: the sweep request, the cell under test and the results.
interface oai22_arc_bist_if;
    logic        START;
    logic        ZN;
    logic        A1;
    logic        A2;
    logic        B1;
    logic        B2;
    logic        BUSY;
    logic        DONE;
    logic        PASS;
    logic [4:0]  FAIL_CNT;
    logic [15:0] FAIL_MASK;
    logic [3:0]  FIRST_FAIL;

    // Sequencer side: takes the request and the cell output, drives the rest.
    modport slave (
        input  START,
        input  ZN,
        output A1,
        output A2,
        output B1,
        output B2,
        output BUSY,
        output DONE,
        output PASS,
        output FAIL_CNT,
        output FAIL_MASK,
        output FIRST_FAIL
    );

    // Environment side: issues the request, returns the cell output, reads results.
    modport master (
        output START,
        output ZN,
        input  A1,
        input  A2,
        input  B1,
        input  B2,
        input  BUSY,
        input  DONE,
        input  PASS,
        input  FAIL_CNT,
        input  FAIL_MASK,
        input  FIRST_FAIL
    );
endinterface

// File: rtl/oai22_arc_bist.sv
// Self-test sequencer for a single OAI22 cell. On START it applies all 16
// input vectors {A1,A2,B1,B2} in ascending order, waits SETTLE_CYCLES after
// each one, samples ZN against ~((A1|A2)&(B1|B2)) and accumulates a fail
// count, a per-vector fail mask and the lowest failing vector.
module oai22_arc_bist #(
    parameter int SETTLE_CYCLES = 2   // legal range 1..15
) (
    input  logic              CK,
    input  logic              RN,
    oai22_arc_bist_if.slave   bus
);

    // FSM encoding kept as plain constants so the state register can be
    // probed in gate-level netlists without enum support.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] L_CNT_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] L_VEC_LAST = 4'd15;

    logic [1:0]  r_state;
    logic [3:0]  r_vec;
    logic [3:0]  r_cnt;
    logic [3:0]  r_drive;
    logic        r_busy;
    logic        r_done;
    logic [4:0]  r_fail_cnt;
    logic [15:0] r_fail_mask;
    logic [3:0]  r_first_fail;

    logic [1:0]  w_state_nxt;
    logic        w_start_go;
    logic        w_cnt_last;
    logic        w_vec_last;
    logic        w_in_sample;
    logic        w_expected;
    logic        w_mismatch;

    // A sweep may only be launched from rest; START during a sweep is ignored.
    assign w_start_go  = bus.START && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_cnt_last  = (r_cnt == L_CNT_LAST);
    assign w_vec_last  = (r_vec == L_VEC_LAST);
    assign w_in_sample = (r_state == S_SAMPLE);

    // Golden OAI22 response for the vector currently presented to the cell.
    assign w_expected = ~((r_drive[3] | r_drive[2]) & (r_drive[1] | r_drive[0]));

    // Case inequality so an X or Z on ZN is scored as a failure in simulation.
    assign w_mismatch = (bus.ZN !== w_expected);

    // Next-state decode for the sweep FSM.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // w_state_nxt unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.START) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                w_state_nxt = w_vec_last ? S_DONE : S_SETTLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus the vector index and settle counter that pace the sweep.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state <= S_IDLE;
            r_vec   <= 4'd0;
            r_cnt   <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            r_state <= w_state_nxt;
            if (w_start_go) begin
                r_vec <= 4'd0;
                r_cnt <= 4'd0;
            end else if (w_in_sample) begin
                r_cnt <= 4'd0;
                if (!w_vec_last) begin
                    r_vec <= r_vec + 4'd1;
                end
            end else if (r_state == S_SETTLE) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Cell input flops: follow the vector during a sweep, parked at 0 otherwise.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_drive <= 4'd0;
        end else if (w_start_go) begin
            r_drive <= 4'd0;
        end else if (w_in_sample) begin
            r_drive <= w_vec_last ? 4'd0 : (r_vec + 4'd1);
        end
    end

    // Status flags registered from the next state so they line up with it.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_SAMPLE);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    // Result accumulation: cleared on launch, updated once per vector at SAMPLE.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_fail_cnt   <= 5'd0;
            r_fail_mask  <= 16'h0000;
            r_first_fail <= 4'd0;
        end else if (w_start_go) begin
            r_fail_cnt   <= 5'd0;
            r_fail_mask  <= 16'h0000;
            r_first_fail <= 4'd0;
        end else if (w_in_sample && w_mismatch) begin
            r_fail_mask[r_vec] <= 1'b1;
            r_fail_cnt         <= r_fail_cnt + 5'd1;
            // An empty count means this is the first failure of the sweep.
            if (r_fail_cnt == 5'd0) begin
                r_first_fail <= r_vec;
            end
        end
    end

    assign bus.A1         = r_drive[3];
    assign bus.A2         = r_drive[2];
    assign bus.B1         = r_drive[1];
    assign bus.B2         = r_drive[0];
    assign bus.BUSY       = r_busy;
    assign bus.DONE       = r_done;
    assign bus.PASS       = r_done && (r_fail_cnt == 5'd0);
    assign bus.FAIL_CNT   = r_fail_cnt;
    assign bus.FAIL_MASK  = r_fail_mask;
    assign bus.FIRST_FAIL = r_first_fail;

endmodule

// File: tb/tb_oai22_arc_bist.sv
// Self-checking bench for oai22_arc_bist: two instances (settle 2 and 1)
// driving a modelled OAI22 cell that can be ideal, stuck-at-0 or stuck-at-1.
module tb_oai22_arc_bist;

    localparam int S0 = 2;
    localparam int S1 = 1;

    typedef struct packed {
        logic [3:0]  drv;
        logic        busy;
        logic        done;
        logic        pass;
        logic [4:0]  cnt;
        logic [15:0] mask;
        logic [3:0]  first;
    } obs_t;

    logic CK;
    logic RN;
    int   cell_mode;      // 0 ideal, 1 stuck-at-0, 2 stuck-at-1
    int   n_checks;
    int   n_pass;

    oai22_arc_bist_if bus0 ();
    oai22_arc_bist_if bus1 ();

    oai22_arc_bist #(.SETTLE_CYCLES(S0)) u_dut0 (.CK(CK), .RN(RN), .bus(bus0));
    oai22_arc_bist #(.SETTLE_CYCLES(S1)) u_dut1 (.CK(CK), .RN(RN), .bus(bus1));

    initial CK = 1'b0;
    always #5 CK = ~CK;

    function automatic logic ideal_fn(input logic [3:0] v);
        return ~((v[3] | v[2]) & (v[1] | v[0]));
    endfunction

    function automatic logic cell_fn(input int mode, input logic [3:0] v);
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        return ideal_fn(v);
    endfunction

    assign bus0.ZN = cell_fn(cell_mode, {bus0.A1, bus0.A2, bus0.B1, bus0.B2});
    assign bus1.ZN = cell_fn(cell_mode, {bus1.A1, bus1.A2, bus1.B1, bus1.B2});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Expected outputs t edges after the launching edge, from the sweep rules.
    function automatic obs_t model_out(input bit started, input int t, input int s, input int mode);
        obs_t e;
        int   per;
        int   n;
        e = '0;
        if (!started) return e;
        per = s + 1;
        if (t < 16 * per) begin
            e.busy = 1'b1;
            e.drv  = 4'(t / per);
        end else begin
            e.done = 1'b1;
        end
        n = (t / per > 16) ? 16 : t / per;
        for (int k = 0; k < n; k++) begin
            if (cell_fn(mode, 4'(k)) !== ideal_fn(4'(k))) begin
                if (e.cnt == 5'd0) e.first = 4'(k);
                e.mask[k] = 1'b1;
                e.cnt     = e.cnt + 5'd1;
            end
        end
        e.pass = e.done && (e.cnt == 5'd0);
        return e;
    endfunction

    bit m_started [2];
    int m_t       [2];
    int m_mode    [2];

    // Model bookkeeping: launch, ignore-while-busy, restart from done, reset.
    always @(posedge CK or negedge RN) begin
        if (!RN) begin
            for (int i = 0; i < 2; i++) begin
                m_started[i] = 1'b0;
                m_t[i]       = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic st;
                int   len;
                st  = (i == 0) ? bus0.START : bus1.START;
                len = 16 * (((i == 0) ? S0 : S1) + 1);
                if (st && !(m_started[i] && m_t[i] < len)) begin
                    m_started[i] = 1'b1;
                    m_t[i]       = 0;
                    m_mode[i]    = cell_mode;
                end else if (m_started[i] && m_t[i] < len) begin
                    m_t[i]++;
                end
            end
        end
    end

    task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
        check({tag, ".drv"},   32'(a.drv),   32'(e.drv));
        check({tag, ".busy"},  32'(a.busy),  32'(e.busy));
        check({tag, ".done"},  32'(a.done),  32'(e.done));
        check({tag, ".pass"},  32'(a.pass),  32'(e.pass));
        check({tag, ".cnt"},   32'(a.cnt),   32'(e.cnt));
        check({tag, ".mask"},  32'(a.mask),  32'(e.mask));
        check({tag, ".first"}, 32'(a.first), 32'(e.first));
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge CK) begin
        if (RN === 1'b1) begin
            obs_t a0;
            obs_t a1;
            a0 = {bus0.A1, bus0.A2, bus0.B1, bus0.B2, bus0.BUSY, bus0.DONE, bus0.PASS,
                  bus0.FAIL_CNT, bus0.FAIL_MASK, bus0.FIRST_FAIL};
            a1 = {bus1.A1, bus1.A2, bus1.B1, bus1.B2, bus1.BUSY, bus1.DONE, bus1.PASS,
                  bus1.FAIL_CNT, bus1.FAIL_MASK, bus1.FIRST_FAIL};
            cmp_obs("dut0", a0, model_out(m_started[0], m_t[0], S0, m_mode[0]));
            cmp_obs("dut1", a1, model_out(m_started[1], m_t[1], S1, m_mode[1]));
        end
    end

    task automatic set_start(input int which, input logic v);
        if (which == 0) bus0.START = v;
        else            bus1.START = v;
    endtask

    // One-cycle START; returns at the falling edge right after the launching edge.
    task automatic pulse_start(input int which);
        @(negedge CK);
        set_start(which, 1'b1);
        @(negedge CK);
        set_start(which, 1'b0);
    endtask

    // Count edges until DONE; optionally inject a START or probe the vector.
    task automatic wait_done(input int which, input int inject_e, input int probe_e,
                             input logic [3:0] probe_vec, output int edges);
        logic dn;
        edges = 0;
        dn    = 1'b0;
        while (!dn && edges < 200) begin
            @(negedge CK);
            edges++;
            set_start(which, edges == inject_e);
            if (edges == probe_e)
                check("probe_vec", 32'({bus0.A1, bus0.A2, bus0.B1, bus0.B2}), 32'(probe_vec));
            dn = (which == 0) ? bus0.DONE : bus1.DONE;
        end
        set_start(which, 1'b0);
        if (!dn) check("done_timeout", 32'(edges), 32'(0));
    endtask

    task automatic check_results(input string tag, input int cnt, input int mask,
                                 input int first, input int pass);
        check({tag, "_cnt"},   32'(bus0.FAIL_CNT),   32'(cnt));
        check({tag, "_mask"},  32'(bus0.FAIL_MASK),  32'(mask));
        check({tag, "_first"}, 32'(bus0.FIRST_FAIL), 32'(first));
        check({tag, "_pass"},  32'(bus0.PASS),       32'(pass));
    endtask

    initial begin
        int e;
        n_checks   = 0;
        n_pass     = 0;
        cell_mode  = 0;
        RN         = 1'b0;
        bus0.START = 1'b0;
        bus1.START = 1'b0;

        // Reset state.
        #12;
        check("rst_busy", 32'(bus0.BUSY), 32'(0));
        check("rst_done", 32'(bus0.DONE), 32'(0));
        check("rst_vec",  32'({bus0.A1, bus0.A2, bus0.B1, bus0.B2}), 32'(0));
        check("rst_cnt",  32'(bus0.FAIL_CNT), 32'(0));
        RN = 1'b1;
        repeat (3) @(negedge CK);

        // Ideal cell: 48 edges, vector 3 visible 10 edges in, clean pass.
        pulse_start(0);
        wait_done(0, -1, 10, 4'd3, e);
        check("ideal_edges", 32'(e), 32'(48));
        check_results("ideal", 0, 16'h0000, 0, 1);

        // Stuck-at-0.
        cell_mode = 1;
        repeat (2) @(negedge CK);
        pulse_start(0);
        wait_done(0, -1, -1, 4'd0, e);
        check("sa0_edges", 32'(e), 32'(48));
        check_results("sa0", 7, 16'h111F, 0, 0);

        // Restart from DONE: results clear on the launching edge.
        cell_mode = 0;
        pulse_start(0);
        check("restart_cnt",  32'(bus0.FAIL_CNT),  32'(0));
        check("restart_mask", 32'(bus0.FAIL_MASK), 32'(0));
        check("restart_done", 32'(bus0.DONE),      32'(0));
        check("restart_busy", 32'(bus0.BUSY),      32'(1));
        wait_done(0, -1, -1, 4'd0, e);
        check_results("rerun", 0, 16'h0000, 0, 1);

        // Stuck-at-1.
        cell_mode = 2;
        pulse_start(0);
        wait_done(0, -1, -1, 4'd0, e);
        check_results("sa1", 9, 16'hEEE0, 5, 0);

        // START again at vector 3 is ignored.
        cell_mode = 0;
        pulse_start(0);
        wait_done(0, 10, -1, 4'd0, e);
        check("busy_start_edges", 32'(e), 32'(48));
        check_results("busy_start", 0, 16'h0000, 0, 1);

        // Asynchronous reset while vector 6 is applied, stuck-at-0 results pending.
        cell_mode = 1;
        pulse_start(0);
        repeat (19) @(negedge CK);
        check("pre_rst_cnt", 32'(bus0.FAIL_CNT), 32'(5));
        #1 RN = 1'b0;
        #1;
        check("arst_vec",  32'({bus0.A1, bus0.A2, bus0.B1, bus0.B2}), 32'(0));
        check("arst_busy", 32'(bus0.BUSY),       32'(0));
        check("arst_cnt",  32'(bus0.FAIL_CNT),   32'(0));
        check("arst_mask", 32'(bus0.FAIL_MASK),  32'(0));
        check("arst_first",32'(bus0.FIRST_FAIL), 32'(0));
        @(negedge CK);
        #1 RN = 1'b1;
        repeat (5) @(negedge CK);
        check("post_rst_busy", 32'(bus0.BUSY), 32'(0));
        check("post_rst_done", 32'(bus0.DONE), 32'(0));
        cell_mode = 0;
        pulse_start(0);
        wait_done(0, -1, -1, 4'd0, e);
        check("post_rst_edges", 32'(e), 32'(48));
        check_results("post_rst", 0, 16'h0000, 0, 1);

        // Settle of one cycle: 32 edges.
        pulse_start(1);
        wait_done(1, -1, -1, 4'd0, e);
        check("s1_edges", 32'(e), 32'(32));
        check("s1_pass",  32'(bus1.PASS), 32'(1));

        repeat (2) @(negedge CK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
